window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator for the haze-removal pipeline. Accepts a raster-order 8-bit pixel stream, buffers the two previous image rows in line buffers, and presents each fully-interior 3x3 window as nine parallel pixels, `out1`..`out9`, with a valid strobe. These outputs drive the nine-input kernel blocks (e.g. Gaussian/P-type filters) directly, one window per accepted pixel once the buffers are primed.

---
 rtl/window_3x3_gen.sv | 95 +++++++++
 tb/tb_window_3x3_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 window generator over two line buffers,
// emitting only fully-interior windows of a raster pixel stream.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [DATA_W-1:0] out8,
    output logic [DATA_W-1:0] out9,
    output logic              frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    typedef enum logic {FILL, ACTIVE} state_t;
    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DATA_W-1:0] r_lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] r_t1, r_t2, r_m1, r_m2, r_b1, r_b2;
    logic [DATA_W-1:0] w_lb0, w_lb1;
    logic w_last_col, w_last_row, w_emit;
    assign w_lb0      = r_lb0[r_col];
    assign w_lb1      = r_lb1[r_col];
    assign w_last_col = r_col == CW'(IMG_WIDTH - 1);
    assign w_last_row = r_row == RW'(IMG_HEIGHT - 1);
    // Line buffers are never cleared; FILL keeps stale rows from being emitted.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb0[r_col] <= in_data;
            r_lb1[r_col] <= w_lb0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            r_row <= !w_last_col ? r_row : w_last_row ? '0 : r_row + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= FILL;
        else
            r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = !in_valid ? r_state :
                      (r_state == FILL) ? ((w_last_col && r_row == RW'(1)) ? ACTIVE : FILL) :
                      ((w_last_col && w_last_row) ? FILL : ACTIVE);
    end
    always_comb begin
        w_emit = in_valid && r_state == ACTIVE && r_col >= CW'(2);
    end
    // Two delay stages per row; the output registers act as the third column.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_t1, r_t2, r_m1, r_m2, r_b1, r_b2} <= '0;
        end else if (in_valid) begin
            r_t1 <= r_t2;
            r_t2 <= w_lb1;
            r_m1 <= r_m2;
            r_m2 <= w_lb0;
            r_b1 <= r_b2;
            r_b2 <= in_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {out1, out2, out3, out4, out5, out6, out7, out8, out9} <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= w_emit;
            frame_done <= in_valid && w_last_col && w_last_row;
            if (w_emit)
                {out1, out2, out3, out4, out5, out6, out7, out8, out9} <=
                    {r_t1, r_t2, w_lb1, r_m1, r_m2, w_lb0, r_b1, r_b2, in_data};
        end
    end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: table vectors, hand sequences and randomized gaps on a
// 4x4 frame, checked every cycle against a frame-image reference model.
module tb_window_3x3_gen;
    localparam int W = 4;
    localparam int H = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic out_valid, frame_done;
    logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9;
    int checks = 0;
    int failures = 0;
    logic [7:0] img [H][W];
    int idx = 0;
    logic [71:0] m_last = '0;
    int n_win = 0;
    int n_done = 0;
    typedef struct {
        logic [7:0]  d;
        bit          v;
        bit          dn;
        logic [71:0] w;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid),
        .out1(o1), .out2(o2), .out3(o3), .out4(o4), .out5(o5),
        .out6(o6), .out7(o7), .out8(o8), .out9(o9),
        .frame_done(frame_done)
    );

    function automatic logic [71:0] dut_win();
        return {o1, o2, o3, o4, o5, o6, o7, o8, o9};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, then advance the model and compare every output.
    task automatic step(input bit v, input logic [7:0] d);
        bit exp_v, exp_d;
        int r, c;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        exp_v = 0;
        exp_d = 0;
        if (rst) begin
            idx    = 0;
            m_last = '0;
        end else if (v) begin
            r = idx / W;
            c = idx % W;
            img[r][c] = d;
            exp_d = (idx == W * H - 1);
            if (r >= 2 && c >= 2) begin
                exp_v = 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m_last = {m_last[63:0], img[r-2+i][c-2+j]};
            end
            idx = (idx + 1) % (W * H);
        end
        chk("out_valid", {71'd0, out_valid}, {71'd0, exp_v});
        chk("frame_done", {71'd0, frame_done}, {71'd0, exp_d});
        chk("window", dut_win(), m_last);
        n_win  += int'(out_valid);
        n_done += int'(frame_done);
    endtask

    task automatic do_reset(input int n, input bit v);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step(v, 8'(i + 77));
        rst = 1'b0;
    endtask

    initial begin
        int w0, d0;
        for (int i = 0; i < 16; i++) begin
            tbl[i].d  = 8'(i);
            tbl[i].v  = 0;
            tbl[i].dn = 0;
            tbl[i].w  = '0;
        end
        tbl[10].w = 72'h00_01_02_04_05_06_08_09_0A;
        tbl[11].w = 72'h01_02_03_05_06_07_09_0A_0B;
        tbl[12].w = tbl[11].w;
        tbl[13].w = tbl[11].w;
        tbl[14].w = 72'h04_05_06_08_09_0A_0C_0D_0E;
        tbl[15].w = 72'h05_06_07_09_0A_0B_0D_0E_0F;
        tbl[10].v = 1;
        tbl[11].v = 1;
        tbl[14].v = 1;
        tbl[15].v = 1;
        tbl[15].dn = 1;

        // rst held high with in_valid high: everything stays 0
        do_reset(4, 1);

        // table-driven frame 0..15, in_valid held high
        for (int i = 0; i < 16; i++) begin
            step(1, tbl[i].d);
            chk($sformatf("tbl_valid[%0d]", i), {71'd0, out_valid}, {71'd0, tbl[i].v});
            chk($sformatf("tbl_done[%0d]", i), {71'd0, frame_done}, {71'd0, tbl[i].dn});
            chk($sformatf("tbl_win[%0d]", i), dut_win(), tbl[i].w);
        end
        step(0, 8'hFF);
        chk("idle_after_frame_valid", {71'd0, out_valid}, 72'd0);

        // same stream with pseudo-random 50% gaps
        w0 = n_win;
        d0 = n_done;
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(1) == 0) step(0, 8'($urandom));
            step(1, 8'(i));
        end
        step(0, 8'h00);
        chk("gap_frame_windows", 72'(n_win - w0), 72'd4);
        chk("gap_frame_done", 72'(n_done - d0), 72'd1);

        // two back-to-back frames; second frame 100..115
        w0 = n_win;
        d0 = n_win;
        d0 = n_done;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) begin
                step(1, 8'(f * 100 + i));
                if (f == 1 && i == 10)
                    chk("frame2_first_window", dut_win(), 72'h64_65_66_68_69_6A_6C_6D_6E);
            end
        step(0, 8'h00);
        chk("two_frame_windows", 72'(n_win - w0), 72'd8);
        chk("two_frame_done", 72'(n_done - d0), 72'd2);

        // reset after 7 pixels, then a full frame
        for (int i = 0; i < 7; i++) step(1, 8'(50 + i));
        do_reset(2, 1);
        chk("reset_clears_window", dut_win(), 72'd0);
        w0 = n_win;
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i));
            if (i == 9) chk("no_window_before_px10", 72'(n_win - w0), 72'd0);
        end
        chk("reset_frame_windows", 72'(n_win - w0), 72'd4);
        chk("reset_frame_last", dut_win(), tbl[15].w);

        // randomized frames with random gaps and one mid-frame reset
        w0 = n_win;
        d0 = n_done;
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(3) == 0) step(0, 8'($urandom));
                step(1, 8'($urandom));
            end
        chk("rand_windows", 72'(n_win - w0), 72'd24);
        chk("rand_done", 72'(n_done - d0), 72'd6);
        for (int i = 0; i < 9; i++) step($urandom_range(1) == 1, 8'($urandom));
        do_reset(1, 0);
        for (int k = 0; k < 64; k++) step($urandom_range(1) == 1, 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
